inst_fetch_queue: RTL and testbench
===================================

// Module: inst_fetch_queue
// PURPOSE
//  Instruction queue between the IF stage and the ID stage. Buffers fetched
//  {pc, inst} pairs so IF can keep fetching while ID stalls, and tags
//  misaligned PCs with a fetch-address exception bit (ADEF).
//  All queued entries are discarded on exception, ertn or taken-branch redirect.
// PARAMETERS
//  DEPTH  4  number of entries; power of two, >= 2
//  AW     2  pointer width, log2(DEPTH)
// PORTS
//  clk          in   1   clock
//  reset        in   1   synchronous, active-high reset
//  excp_flush   in   1   exception redirect; discard all entries
//  ertn_flush   in   1   ertn redirect; discard all entries
//  br_taken     in   1   taken branch resolved in ID; discard all entries
//  in_valid     in   1   IF presents a valid {pc, inst}
//  in_bus       in   64  {pc[31:0], inst[31:0]} from IF
//  in_allow_in  out  1   queue can accept an entry this cycle (to IF)
//  out_valid    out  1   head entry valid (to ID)
//  out_bus      out  65  {adef, pc[31:0], inst[31:0]} head entry
//  out_allow_in in   1   ID accepts the head entry this cycle
//  count        out  AW+1 number of occupied entries, 0..DEPTH
// BEHAVIOUR
//  - Storage: DEPTH x 65-bit array; write pointer wp, read pointer rp (AW bits,
//    wrap modulo DEPTH); occupancy cnt (AW+1 bits).
//  - Reset values: wp=0, rp=0, cnt=0, out_valid=0, in_allow_in=1, count=0.
//    Array contents are not reset; out_bus is don't-care while out_valid=0.
//  - flush = excp_flush | ertn_flush | br_taken.
//  - push = in_valid & in_allow_in & ~flush.
//  - pop  = out_valid & out_allow_in & ~flush.
//  - in_allow_in = (cnt != DEPTH). It depends on registered state only; there is
//    no combinational path from out_allow_in to in_allow_in.
//  - out_valid = (cnt != 0). out_bus = mem[rp], read combinationally from the head.
//  - Entry written: {adef, in_bus}, where adef = (in_bus[33:32] != 2'b00),
//    i.e. pc[1:0] != 0.
//  - Latency: an entry pushed in cycle N is visible at out_* in cycle N+1.
//    There is no same-cycle bypass from in_* to out_*.
//  - Push only: mem[wp] <= entry, wp++, cnt++.
//  - Pop only: rp++, cnt--.
//  - Push and pop in the same cycle: both pointers advance; cnt is unchanged.
//  - Full (cnt=DEPTH): in_allow_in=0, so no push, even if a pop occurs in the
//    same cycle.
//  - Empty (cnt=0): out_valid=0, so no pop.
//  - Wrap-around: wp and rp roll over from DEPTH-1 to 0 with no special handling.
//  - Flush has priority over push and pop. On flush: wp<=0, rp<=0, cnt<=0 on the
//    next edge. Any entry presented in the flush cycle is dropped. Nothing
//    counts as popped in the flush cycle, even if out_allow_in=1.
//    out_valid=0 in the following cycle.
//  - Simultaneous flush sources are equivalent to a single flush.
//  - Reset mid-operation: all state returns to its reset values on that edge,
//    regardless of flush, push or pop.
//  - Invariant: cnt == (wp - rp) mod DEPTH, except at cnt == DEPTH, where
//    wp == rp.
// TESTING
//  1 Reset: hold reset 2 cycles with in_valid=1 -> out_valid=0, count=0,
//    in_allow_in=1 after release.
//  2 Fill/drain: out_allow_in=0; push pc 0x1c000000..0x1c00000c
//    -> count=4, in_allow_in=0, and a 5th push is ignored.
//    Then out_allow_in=1 -> pcs emerge in order, 1 per cycle; count returns to 0.
//  3 Streaming: in_valid=1 and out_allow_in=1 continuously, pc += 4 for 20 cycles
//    -> count stays 1 after first fill, out pc sequence is in-order, pointers wrap
//    with no loss or duplication.
//  4 Flush: 3 entries queued; assert br_taken with in_valid=1 (pc 0x1c000040)
//    -> next cycle out_valid=0, count=0, pc 0x1c000040 is never output.
//    Repeat with excp_flush, then ertn_flush.
//  5 ADEF: push pc 0x1c000002 -> out_bus[64]=1. Push pc 0x1c000004 -> out_bus[64]=0.
//  6 Full boundary: count=4, pop and in_valid in the same cycle -> pop occurs,
//    push refused, count=3. Next cycle push is accepted, count=4.

Source files
------------

// File: rtl/inst_fetch_queue_if.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch_queue_if
//  Brief    : IF -> queue -> ID handshake bundle for the instruction queue.
//  Revision : 1.0  initial release
// ============================================================================
interface inst_fetch_queue_if #(
    parameter int AW = 2
);
    logic          in_valid;
    logic [63:0]   in_bus;
    logic          in_allow_in;
    logic          out_valid;
    logic [64:0]   out_bus;
    logic          out_allow_in;
    logic [AW:0]   count;

    // Queue side
    modport slave (
        input  in_valid,
        input  in_bus,
        input  out_allow_in,
        output in_allow_in,
        output out_valid,
        output out_bus,
        output count
    );

    // Pipeline side (IF producer plus ID consumer)
    modport master (
        output in_valid,
        output in_bus,
        output out_allow_in,
        input  in_allow_in,
        input  out_valid,
        input  out_bus,
        input  count
    );
endinterface
`default_nettype wire

// File: rtl/inst_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch_queue
//  Brief    : Circular instruction queue between IF and ID; tags misaligned
//             PCs with ADEF and is emptied by any redirect.
//  Revision : 1.0  initial release
// ============================================================================
module inst_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              excp_flush,
    input  logic              ertn_flush,
    input  logic              br_taken,
    inst_fetch_queue_if.slave q
);

    localparam logic [AW:0]   c_full    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_cnt_one = (AW+1)'(1);
    localparam logic [AW-1:0] c_ptr_one = AW'(1);

    logic [64:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;

    logic          w_flush;
    logic          w_push;
    logic          w_pop;
    logic          w_adef;
    logic [64:0]   w_entry;

    // Handshake outputs come from registered occupancy only, never from out_allow_in.
    assign q.in_allow_in = (r_cnt != c_full);
    assign q.out_valid   = (r_cnt != '0);
    assign q.out_bus     = r_mem[r_rp];
    assign q.count       = r_cnt;

    assign w_flush = excp_flush | ertn_flush | br_taken;
    assign w_push  = q.in_valid  & q.in_allow_in  & ~w_flush;
    assign w_pop   = q.out_valid & q.out_allow_in & ~w_flush;

    assign w_adef  = (q.in_bus[33:32] != 2'b00);
    assign w_entry = {w_adef, q.in_bus};

    // Storage is not reset; the head is only meaningful while out_valid is high.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp] <= w_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_flush) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + c_ptr_one;
            end
            if (w_pop) begin
                r_rp <= r_rp + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + c_cnt_one;
                2'b01:   r_cnt <= r_cnt - c_cnt_one;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_fetch_queue
//  Brief    : Vector table, streaming sequence and random traffic against a
//             queue-based model of the instruction fetch queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_inst_fetch_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam logic [31:0] c_imask = 32'hA5A5A5A5;

    logic clk = 1'b0;
    logic reset;
    logic excp_flush;
    logic ertn_flush;
    logic br_taken;

    inst_fetch_queue_if #(.AW(AW)) bus ();

    inst_fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .excp_flush (excp_flush),
        .ertn_flush (ertn_flush),
        .br_taken   (br_taken),
        .q          (bus.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [64:0] mq [$];
    bit model_ok = 1'b0;

    typedef struct {
        logic        rst, ex, er, bt, iv;
        logic [31:0] pc;
        logic        oa;
        logic        chk, ev;
        logic [2:0]  ec;
        logic        ea;
        logic [31:0] epc;
        logic        eadef;
    } vec_t;

    vec_t tbl [40];

    function automatic vec_t mk(logic rst, logic ex, logic er, logic bt, logic iv,
                                logic [31:0] pc, logic oa, logic chk, logic ev,
                                logic [2:0] ec, logic ea, logic [31:0] epc, logic eadef);
        vec_t v;
        v.rst = rst; v.ex = ex; v.er = er; v.bt = bt; v.iv = iv; v.pc = pc; v.oa = oa;
        v.chk = chk; v.ev = ev; v.ec = ec; v.ea = ea; v.epc = epc; v.eadef = eadef;
        return v;
    endfunction

    task automatic cmp(input string nm, input logic [64:0] act, input logic [64:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic ex, input logic er, input logic bt,
                         input logic iv, input logic [31:0] pc, input logic oa);
        reset            = rst;
        excp_flush       = ex;
        ertn_flush       = er;
        br_taken         = bt;
        bus.in_valid     = iv;
        bus.in_bus       = {pc, pc ^ c_imask};
        bus.out_allow_in = oa;
    endtask

    // Expected outputs derive purely from the model queue contents.
    task automatic check_model();
        if (model_ok) begin
            cmp("model_valid", 65'(bus.out_valid),   65'(mq.size() != 0));
            cmp("model_allow", 65'(bus.in_allow_in), 65'(mq.size() < DEPTH));
            cmp("model_count", 65'(bus.count),       65'(mq.size()));
            if (mq.size() != 0) begin
                cmp("model_head", bus.out_bus, mq[0]);
            end
        end
    endtask

    task automatic tick();
        logic [31:0] pc;
        bit pop, push;
        pc   = bus.in_bus[63:32];
        pop  = (mq.size() != 0) && bus.out_allow_in;
        push = bus.in_valid && (mq.size() < DEPTH);
        @(posedge clk);
        if (reset) begin
            mq.delete();
            model_ok = 1'b1;
        end else if (excp_flush || ertn_flush || br_taken) begin
            mq.delete();
        end else begin
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back({pc[1:0] != 2'b00, pc, pc ^ c_imask});
        end
        #1;
    endtask

    initial begin
        logic [31:0] base;
        logic [31:0] rpc;
        int i = 0;
        tbl[i++] = mk(1,0,0,0,1,32'h1c0000f0,1, 0,0,0,1,32'h0,0);
        tbl[i++] = mk(1,0,0,0,1,32'h1c0000f0,1, 1,0,0,1,32'h0,0);
        tbl[i++] = mk(0,0,0,0,0,32'h0,0,        1,0,0,1,32'h0,0);
        tbl[i++] = mk(0,0,0,0,1,32'h1c000000,0, 1,0,0,1,32'h0,0);
        tbl[i++] = mk(0,0,0,0,1,32'h1c000004,0, 1,1,1,1,32'h1c000000,0);
        tbl[i++] = mk(0,0,0,0,1,32'h1c000008,0, 1,1,2,1,32'h1c000000,0);
        tbl[i++] = mk(0,0,0,0,1,32'h1c00000c,0, 1,1,3,1,32'h1c000000,0);
        tbl[i++] = mk(0,0,0,0,1,32'h1c000010,0, 1,1,4,0,32'h1c000000,0);
        tbl[i++] = mk(0,0,0,0,0,32'h0,1,        1,1,4,0,32'h1c000000,0);
        tbl[i++] = mk(0,0,0,0,0,32'h0,1,        1,1,3,1,32'h1c000004,0);
        tbl[i++] = mk(0,0,0,0,0,32'h0,1,        1,1,2,1,32'h1c000008,0);
        tbl[i++] = mk(0,0,0,0,0,32'h0,1,        1,1,1,1,32'h1c00000c,0);
        tbl[i++] = mk(0,0,0,0,0,32'h0,1,        1,0,0,1,32'h0,0);
        tbl[i++] = mk(0,0,0,0,1,32'h1c000002,0, 1,0,0,1,32'h0,0);
        tbl[i++] = mk(0,0,0,0,1,32'h1c000004,1, 1,1,1,1,32'h1c000002,1);
        tbl[i++] = mk(0,0,0,0,0,32'h0,1,        1,1,1,1,32'h1c000004,0);
        tbl[i++] = mk(0,0,0,0,0,32'h0,0,        1,0,0,1,32'h0,0);
        tbl[i++] = mk(0,0,0,0,1,32'h1c000100,0, 1,0,0,1,32'h0,0);
        tbl[i++] = mk(0,0,0,0,1,32'h1c000104,0, 1,1,1,1,32'h1c000100,0);
        tbl[i++] = mk(0,0,0,0,1,32'h1c000108,0, 1,1,2,1,32'h1c000100,0);
        tbl[i++] = mk(0,0,0,0,1,32'h1c00010c,0, 1,1,3,1,32'h1c000100,0);
        tbl[i++] = mk(0,0,0,0,1,32'h1c000110,1, 1,1,4,0,32'h1c000100,0);
        tbl[i++] = mk(0,0,0,0,1,32'h1c000110,0, 1,1,3,1,32'h1c000104,0);
        tbl[i++] = mk(0,0,0,0,0,32'h0,0,        1,1,4,0,32'h1c000104,0);
        tbl[i++] = mk(0,0,0,1,1,32'h1c000040,1, 1,1,4,0,32'h1c000104,0);
        tbl[i++] = mk(0,0,0,0,0,32'h0,1,        1,0,0,1,32'h0,0);
        tbl[i++] = mk(0,0,0,0,1,32'h1c000200,0, 1,0,0,1,32'h0,0);
        tbl[i++] = mk(0,0,0,0,1,32'h1c000204,0, 1,1,1,1,32'h1c000200,0);
        tbl[i++] = mk(0,0,0,0,1,32'h1c000208,0, 1,1,2,1,32'h1c000200,0);
        tbl[i++] = mk(0,1,0,0,1,32'h1c000040,1, 1,1,3,1,32'h1c000200,0);
        tbl[i++] = mk(0,0,0,0,0,32'h0,0,        1,0,0,1,32'h0,0);
        tbl[i++] = mk(0,0,0,0,1,32'h1c000300,0, 1,0,0,1,32'h0,0);
        tbl[i++] = mk(0,0,0,0,1,32'h1c000304,0, 1,1,1,1,32'h1c000300,0);
        tbl[i++] = mk(0,0,0,0,1,32'h1c000308,0, 1,1,2,1,32'h1c000300,0);
        tbl[i++] = mk(0,0,1,0,1,32'h1c000040,0, 1,1,3,1,32'h1c000300,0);
        tbl[i++] = mk(0,0,0,0,0,32'h0,0,        1,0,0,1,32'h0,0);
        tbl[i++] = mk(0,0,0,0,1,32'h1c000400,0, 1,0,0,1,32'h0,0);
        tbl[i++] = mk(0,0,0,0,1,32'h1c000404,0, 1,1,1,1,32'h1c000400,0);
        tbl[i++] = mk(1,0,0,0,1,32'h1c000408,1, 1,1,2,1,32'h1c000400,0);
        tbl[i++] = mk(0,0,0,0,0,32'h0,0,        1,0,0,1,32'h0,0);

        for (int k = 0; k < 40; k++) begin
            drive(tbl[k].rst, tbl[k].ex, tbl[k].er, tbl[k].bt, tbl[k].iv, tbl[k].pc, tbl[k].oa);
            #1;
            if (tbl[k].chk) begin
                cmp($sformatf("tbl%0d_valid", k), 65'(bus.out_valid),   65'(tbl[k].ev));
                cmp($sformatf("tbl%0d_count", k), 65'(bus.count),       65'(tbl[k].ec));
                cmp($sformatf("tbl%0d_allow", k), 65'(bus.in_allow_in), 65'(tbl[k].ea));
                if (tbl[k].ev) begin
                    cmp($sformatf("tbl%0d_head", k), bus.out_bus,
                        {tbl[k].eadef, tbl[k].epc, tbl[k].epc ^ c_imask});
                end
            end
            check_model();
            tick();
        end

        // Continuous streaming: occupancy settles at one, pointers wrap several times.
        base = 32'h1c001000;
        for (int k = 0; k < 20; k++) begin
            drive(0, 0, 0, 0, 1, base + 32'(4 * k), 1);
            #1;
            if (k == 0) begin
                cmp("stream_count0", 65'(bus.count), 65'(0));
            end else begin
                cmp($sformatf("stream%0d_count", k), 65'(bus.count), 65'(1));
                cmp($sformatf("stream%0d_pc", k), 65'(bus.out_bus[63:32]),
                    65'(base + 32'(4 * (k - 1))));
            end
            check_model();
            tick();
        end

        // Random traffic including redirects, mid-run reset and misaligned PCs.
        for (int k = 0; k < 800; k++) begin
            rpc = 32'h1c000000 + 32'($urandom_range(0, 4095) << 2);
            if ($urandom_range(0, 7) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            drive(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 24) == 0),
                  ($urandom_range(0, 24) == 0),
                  ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 3) != 0),
                  rpc,
                  ($urandom_range(0, 2) != 0));
            #1;
            check_model();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
